// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution unit: branch opcodes, FSM
// states and the flush counter width.
package branch_pkg;

  localparam logic BR_BNE = 1'b0;
  localparam logic BR_BLT = 1'b1;

  localparam int FLUSH_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } br_state_e;

  function automatic logic br_taken(input logic op, input logic ne, input logic lt);
    return (op == BR_BLT) ? lt : ne;
  endfunction

endpackage

// File: rtl/target_adder.sv
// Ripple-carry adder for the branch target, structured like the ALU adder.
// Carry-out of the MSB is never formed; the sum wraps modulo 2^DATA_W.
module target_adder #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o
);

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    logic cin;
    if (i == 0) begin : g_lsb
      assign cin = 1'b0;
    end else begin : g_chain
      assign cin = (a_i[i-1] & b_i[i-1]) | (g_bit[i-1].cin & (a_i[i-1] ^ b_i[i-1]));
    end
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ cin;
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: redirect PC and multi-cycle flush on taken
// branches. Define BRANCH_RESOLVE_STATS_EN to build the 32-bit stats counters.
import branch_pkg::*;

module branch_resolve #(
  parameter int FLUSH_CYCLES = 2,
  parameter int DATA_W       = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              br_valid,
  input  logic              br_op,
  input  logic              is_not_equal,
  input  logic              is_less_than,
  input  logic [DATA_W-1:0] pc_plus1,
  input  logic [DATA_W-1:0] imm_offset,
  input  logic              stall,
  output logic              br_ready,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              flush,
  output logic [31:0]       br_count,
  output logic [31:0]       br_taken_count
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [FLUSH_CNT_W-1:0] CNT_ONE    = FLUSH_CNT_W'(1);

  br_state_e               state_q;
  logic [FLUSH_CNT_W-1:0]  flush_cnt_q;
  logic [DATA_W-1:0]       redirect_pc_q;
  logic [DATA_W-1:0]       target_d;
  logic                    accept;
  logic                    taken;

  target_adder #(.DATA_W(DATA_W)) u_target_adder (
    .a_i  (pc_plus1),
    .b_i  (imm_offset),
    .sum_o(target_d)
  );

  assign accept = br_valid & br_ready & ~stall;
  assign taken  = br_taken(br_op, is_not_equal, is_less_than);

  // REDIRECT holds the counter; FLUSH counts it down and exits when it reads 1.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      flush_cnt_q   <= '0;
      redirect_pc_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && taken) begin
            state_q       <= REDIRECT;
            flush_cnt_q   <= FLUSH_INIT;
            redirect_pc_q <= target_d;
          end
        end
        REDIRECT: begin
          state_q <= (flush_cnt_q != '0) ? FLUSH : IDLE;
        end
        FLUSH: begin
          flush_cnt_q <= flush_cnt_q - CNT_ONE;
          if (flush_cnt_q == CNT_ONE) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign br_ready       = (state_q == IDLE);
  assign redirect_valid = (state_q == REDIRECT);
  assign flush          = (state_q != IDLE);
  assign redirect_pc    = redirect_pc_q;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] br_count_q;
  logic [31:0] br_taken_count_q;
  logic [31:0] br_count_d;
  logic [31:0] br_taken_count_d;

  assign br_count_d       = br_count_q + 32'd1;
  assign br_taken_count_d = br_taken_count_q + 32'd1;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      br_count_q       <= '0;
      br_taken_count_q <= '0;
    end else if (accept) begin
      br_count_q <= br_count_d;
      if (taken) br_taken_count_q <= br_taken_count_d;
    end
  end

  assign br_count       = br_count_q;
  assign br_taken_count = br_taken_count_q;
`else
  assign br_count       = '0;
  assign br_taken_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: randomized and directed branches are
// modelled by acceptance rules and cycle windows; a monitor checks every cycle.
module tb_branch_resolve;

  localparam int FC = 4;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          br_valid = 1'b0;
  logic          br_op = 1'b0;
  logic          is_not_equal = 1'b0;
  logic          is_less_than = 1'b0;
  logic [DW-1:0] pc_plus1 = '0;
  logic [DW-1:0] imm_offset = '0;
  logic          stall = 1'b0;
  logic          br_ready;
  logic          redirect_valid;
  logic [DW-1:0] redirect_pc;
  logic          flush;
  logic [31:0]   br_count;
  logic [31:0]   br_taken_count;

  always #5 clock = ~clock;

  branch_resolve #(.FLUSH_CYCLES(FC), .DATA_W(DW)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .br_valid      (br_valid),
    .br_op         (br_op),
    .is_not_equal  (is_not_equal),
    .is_less_than  (is_less_than),
    .pc_plus1      (pc_plus1),
    .imm_offset    (imm_offset),
    .stall         (stall),
    .br_ready      (br_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .flush         (flush),
    .br_count      (br_count),
    .br_taken_count(br_taken_count)
  );

  typedef struct {
    logic [31:0] pc;
    int          ed;
  } redir_t;

  redir_t      exp_q[$];
  int          cyc = 0;
  int          busy_end = 0;
  int          acc_edge = 0;
  int          n_acc = 0;
  int          n_taken = 0;
  logic [31:0] last_pc = '0;
  bit          mon_en = 1'b0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] exp_stat(input int n);
`ifdef BRANCH_RESOLVE_STATS_EN
    return 32'(n);
`else
    return 32'd0 & 32'(n);
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", nm, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs and apply the acceptance rules to the model.
  task automatic drive(input bit v, input bit op, input bit ne, input bit lt,
                       input logic [31:0] pc, input logic [31:0] imm, input bit st);
    int          n;
    bit          tk;
    logic [31:0] tgt;
    @(negedge clock);
    br_valid = v; br_op = op; is_not_equal = ne; is_less_than = lt;
    pc_plus1 = pc; imm_offset = imm; stall = st;
    n = cyc + 1;
    if (v && (cyc >= busy_end) && !st) begin
      n_acc++;
      tk = op ? lt : ne;
      if (tk) begin
        n_taken++;
        tgt = pc + imm;
        last_pc = tgt;
        exp_q.push_back('{pc: tgt, ed: n});
        acc_edge = n;
        busy_end = n + FC;
      end
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  // Monitor: samples 1 time unit after every rising edge.
  always begin
    int     e;
    bit     exp_rv;
    redir_t r;
    @(posedge clock);
    #1;
    if (mon_en) begin
      e = cyc;
      while (exp_q.size() > 0 && exp_q[0].ed < e) r = exp_q.pop_front();
      exp_rv = (exp_q.size() > 0) && (exp_q[0].ed == e);
      check("redirect_valid", 32'(redirect_valid), 32'(exp_rv));
      if (redirect_valid && exp_rv) begin
        r = exp_q.pop_front();
        check("redirect_target", redirect_pc, r.pc);
      end
      check("br_ready", 32'(br_ready), 32'(e >= busy_end));
      check("flush", 32'(flush), 32'((e >= acc_edge) && (e < busy_end)));
      check("redirect_pc_hold", redirect_pc, last_pc);
      check("br_count", br_count, exp_stat(n_acc));
      check("br_taken_count", br_taken_count, exp_stat(n_taken));
    end
  end

  task automatic model_reset();
    exp_q.delete();
    busy_end = 0;
    acc_edge = 0;
    n_acc = 0;
    n_taken = 0;
    last_pc = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_br_ready"}, 32'(br_ready), 32'd1);
    check({tag, "_flush"}, 32'(flush), 32'd0);
    check({tag, "_redirect_valid"}, 32'(redirect_valid), 32'd0);
    check({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    check({tag, "_br_count"}, br_count, 32'd0);
    check({tag, "_br_taken_count"}, br_taken_count, 32'd0);
  endtask

  initial begin
    logic [31:0] pc, imm;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    resetn = 1'b1;
    model_reset();
    mon_en = 1'b1;
    idle(2);

    // Taken BNE with a negative offset.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'hFFFF_FFF0, 1'b0);
    idle(FC + 1);

    // Four back-to-back not-taken BLTs.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, i[0], 1'b0, 32'(i * 4), 32'h40, 1'b0);
    idle(1);

    // Target wrap, then younger branches offered during the flush.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h2, 1'b0);
    for (int i = 0; i < FC + 1; i++) drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h500, 32'h8, 1'b0);
    idle(2);

    // Stall blocks acceptance; stall during the flush is ignored.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h2000, 32'h10, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h2000, 32'h10, 1'b0);
    for (int i = 0; i < FC + 2; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h3000, 32'h4, 1'b1);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      case ($urandom_range(0, 3))
        0: imm = 32'($signed(32'($urandom_range(0, 255))) - 128);
        1: imm = $urandom;
        2: imm = 32'hFFFF_FFFF;
        default: imm = 32'h1;
      endcase
      drive($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), 1'($urandom),
            pc, imm, $urandom_range(0, 4) == 0);
    end
    idle(FC + 2);

    // Reset asserted in the first FLUSH cycle aborts without a clock edge.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h7000, 32'h20, 1'b0);
    @(posedge clock);
    @(posedge clock);
    #3;
    mon_en = 1'b0;
    resetn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    br_valid = 1'b0; stall = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    mon_en = 1'b1;
    idle(FC + 3);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h4, 1'b0);
    idle(FC + 3);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Sequential branch-resolution unit in the execute stage of the pipelined CPU. It consumes the ALU's comparison flags, `is_not_equal` and `is_less_than`, for the branch currently in execute, and decides whether the branch is taken. On a taken branch it issues a registered redirect PC to fetch and asserts a flush for a programmable number of cycles. The pipeline statically predicts not-taken, so only taken branches cause redirect and flush.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: total cycles `flush` is asserted per taken branch; legal range 1..15.
- `DATA_W`, default 32: width of PC, offset and target.

Ports:
- `clock` input 1: single clock; everything updates on the rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `br_valid` input 1: a branch occupies execute and its flags are valid this cycle.
- `br_op` input 1: 0 = BNE, 1 = BLT.
- `is_not_equal` input 1: ALU flag for the branch operands.
- `is_less_than` input 1: ALU flag for the branch operands.
- `pc_plus1` input DATA_W: address of the branch plus 1.
- `imm_offset` input DATA_W: sign-extended branch offset.
- `stall` input 1: pipeline hold; no new branch is accepted while high.
- `br_ready` output 1: high only in the IDLE state.
- `redirect_valid` output 1: single-cycle pulse; fetch loads `redirect_pc`.
- `redirect_pc` output DATA_W: branch target.
- `flush` output 1: squash the fetch/decode stage registers.
- `br_count` output 32: stats counter (see Configuration).
- `br_taken_count` output 32: stats counter (see Configuration).

## Operation
- Acceptance occurs when `br_valid & br_ready & ~stall`.
- Taken condition:
  - BNE: taken = `is_not_equal`.
  - BLT: taken = `is_less_than`.
- Target = `pc_plus1 + imm_offset`, modulo 2^DATA_W. Carry-out is discarded; wrap-around is legal and not flagged.
- FSM states: IDLE, REDIRECT, FLUSH.
  - IDLE → REDIRECT on acceptance with taken. The target is registered into `redirect_pc`, and the flush counter is loaded with FLUSH_CYCLES-1.
  - IDLE → IDLE on acceptance with not-taken. No output changes.
  - REDIRECT: `redirect_valid=1`, `flush=1`. Next state is FLUSH if the counter is nonzero, else IDLE.
  - FLUSH: `flush=1`, and the counter decrements each cycle. The FSM returns to IDLE on the cycle the counter reads 1.
- `stall` only blocks acceptance in IDLE. REDIRECT and FLUSH ignore `stall`; the flush has priority.
- `br_valid` while `br_ready=0` is ignored and is not counted. Those instructions are younger than the branch and are being flushed.
- `redirect_pc` holds its last value outside REDIRECT. It is meaningful only while `redirect_valid` is high.
- Reset values:
  - State is IDLE, so `br_ready=1`.
  - `redirect_valid=0`, `flush=0`, `redirect_pc=0`, counters 0.
- Reset asserted mid-REDIRECT or mid-FLUSH aborts immediately to IDLE with all outputs at reset values. No redirect is replayed after reset.

## Timing
- Redirect latency is 1 cycle. If a branch is accepted at edge N, `redirect_valid` and `flush` are high during cycle N+1.
- `flush` stays high for exactly FLUSH_CYCLES consecutive cycles, starting at N+1.
- `br_ready` returns high in cycle N+1+FLUSH_CYCLES, so back-to-back taken branches are FLUSH_CYCLES+1 cycles apart at minimum.
- Not-taken branches are accepted every cycle with no bubble.
- All outputs are registered or decoded directly from state. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `BRANCH_RESOLVE_STATS_EN`.
- Defined:
  - `br_count` increments on every acceptance.
  - `br_taken_count` increments on every taken acceptance.
  - Both counters are 32-bit, wrap from 0xFFFFFFFF to 0, and are cleared by reset.
- Undefined: no counter flops are built, and both ports are tied to 0. The port list is identical in both builds.

## Structure
- Shared package `branch_pkg` holds:
  - `br_op` encodings (`BR_BNE=1'b0`, `BR_BLT=1'b1`);
  - the FSM state enum (IDLE, REDIRECT, FLUSH);
  - the flush counter width constant (4 bits).
- One sub-module, `target_adder`: a structural DATA_W-bit adder, built the same way as the ALU adder, computing `pc_plus1 + imm_offset`.
- The FSM, flush counter and stats counters stay in the top module.

## Test plan
- Reset then idle → `br_ready=1`, `flush=0`, `redirect_valid=0`, `redirect_pc=0`.
- BNE, `is_not_equal=1`, `pc_plus1=0x100`, `imm_offset=0xFFFFFFF0` → `redirect_pc=0xF0`, pulse at N+1, `flush` high for 2 cycles, `br_ready` high again at N+3.
- BLT, `is_less_than=0`, `br_valid` held every cycle for 4 cycles → no redirect, `flush=0`, `br_count=4`, `br_taken_count=0` (stats build).
- Taken BLT with `pc_plus1=0xFFFFFFFF`, `imm_offset=2` → `redirect_pc=0x1` (wrap). Extra `br_valid` pulses during FLUSH are not counted.
- `stall=1` with `br_valid=1`, taken → no acceptance. Release `stall` → redirect 1 cycle later. Then raise `stall` during FLUSH → `flush` still lasts FLUSH_CYCLES.
- `resetn` asserted in the first FLUSH cycle (FLUSH_CYCLES=4) → `flush=0` and IDLE immediately, without waiting for a clock edge. No redirect after release.
